// File: rtl/imem_arbiter.sv
// Two-port arbiter/sequencer for the registered single-port instruction ROM.
// Define IMEM_ARB_RR_EN for round-robin tie-breaking; otherwise the core has fixed priority.
module imem_arbiter #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned INSTR_CNT = 321
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_err,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e              state_q, state_d;
  logic                owner_dbg_q;
  logic                err_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic                core_rvalid_q, dbg_rvalid_q;
  logic                core_err_q, dbg_err_q;
  logic [DATA_W-1:0]   core_rdata_q, dbg_rdata_q;
  logic                core_wins_tie;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_err;

  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    logic [31:0] idx;
    idx = 32'(a[ADDR_W-1:2]);
    return (a[1:0] != 2'b00) || (idx >= INSTR_CNT);
  endfunction

`ifdef IMEM_ARB_RR_EN
  // Set when debug took the most recent grant; core wins the next tie.
  logic last_dbg_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dbg_q <= 1'b1;
    end else if (core_gnt || dbg_gnt) begin
      last_dbg_q <= dbg_gnt;
    end
  end
  assign core_wins_tie = last_dbg_q;
`else
  assign core_wins_tie = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rst) begin
          if (core_req && (!dbg_req || core_wins_tie)) begin
            core_gnt = 1'b1;
          end else if (dbg_req) begin
            dbg_gnt = 1'b1;
          end
        end
        if (core_gnt || dbg_gnt) state_d = StIssue;
      end
      StIssue:   state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign sel_addr = dbg_gnt ? dbg_addr : core_addr;
  assign sel_err  = addr_err(sel_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      owner_dbg_q   <= 1'b0;
      err_q         <= 1'b0;
      rom_addr_q    <= '0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      core_err_q    <= 1'b0;
      dbg_err_q     <= 1'b0;
      core_rdata_q  <= '0;
      dbg_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      if (core_gnt || dbg_gnt) begin
        rom_addr_q  <= sel_addr;
        owner_dbg_q <= dbg_gnt;
        err_q       <= sel_err;
      end
      if (state_q == StCapture) begin
        if (owner_dbg_q) begin
          dbg_rdata_q  <= err_q ? '0 : rom_data;
          dbg_err_q    <= err_q;
          dbg_rvalid_q <= 1'b1;
        end else begin
          core_rdata_q  <= err_q ? '0 : rom_data;
          core_err_q    <= err_q;
          core_rvalid_q <= 1'b1;
        end
      end
    end
  end

  assign rom_addr    = rom_addr_q;
  assign core_rvalid = core_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign core_err    = core_err_q;
  assign dbg_rvalid  = dbg_rvalid_q;
  assign dbg_rdata   = dbg_rdata_q;
  assign dbg_err     = dbg_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: ROM model, response scoreboard, vector table and
// hand-written sequences for back-to-back, contention, reset and data-hold behaviour.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0, dbg_req = 1'b0;
  logic [13:0] core_addr = '0, dbg_addr = '0;
  logic        core_gnt, core_rvalid, core_err, dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] core_rdata, dbg_rdata;
  logic [13:0] rom_addr;
  logic [31:0] rom_data = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  imem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_addr  (core_addr),
    .core_gnt   (core_gnt),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .core_err   (core_err),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .dbg_err    (dbg_err),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input logic [11:0] idx);
    return {8'h5A, 4'h0, idx, ~idx[7:0]};
  endfunction

  function automatic logic exp_err(input logic [13:0] a);
    return (a[1:0] != 2'b00) || (a[13:2] >= 12'd321);
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr[13:2]);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        dbg;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          gnt_log[$];
  logic [31:0] mdl_core_rdata = '0;
  logic        mdl_core_err = 1'b0;

  function automatic exp_t mk_exp(input logic d, input logic [13:0] a, input int c);
    exp_t e;
    e.dbg  = d;
    e.err  = exp_err(a);
    e.data = e.err ? 32'h0 : rom_word(a[13:2]);
    e.cyc  = c;
    return e;
  endfunction

  // Monitor: retire responses first, then record new grants.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      mdl_core_rdata = '0;
      mdl_core_err   = 1'b0;
      if (core_gnt || dbg_gnt) chk("gnt_in_reset", {core_gnt, dbg_gnt}, 0);
    end else begin
      if (core_gnt && dbg_gnt) chk("double_gnt", 1, 0);
      if (core_rvalid || dbg_rvalid) begin
        if (core_rvalid && dbg_rvalid) chk("double_rvalid", 1, 0);
        if (sbq.size() == 0) begin
          chk("unexpected_rvalid", {core_rvalid, dbg_rvalid}, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rvalid_port", dbg_rvalid, e.dbg);
          chk("rvalid_latency", cyc - e.cyc, 3);
          if (e.dbg) begin
            chk("dbg_rdata", dbg_rdata, e.data);
            chk("dbg_err", dbg_err, e.err);
          end else begin
            chk("core_rdata", core_rdata, e.data);
            chk("core_err", core_err, e.err);
            mdl_core_rdata = e.data;
            mdl_core_err   = e.err;
          end
        end
      end
      if (core_gnt) begin
        sbq.push_back(mk_exp(1'b0, core_addr, cyc));
        gnt_log.push_back(0);
      end
      if (dbg_gnt) begin
        sbq.push_back(mk_exp(1'b1, dbg_addr, cyc));
        gnt_log.push_back(1);
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
  endtask

  task automatic access(input logic d, input logic [13:0] a);
    int n = 0;
    logic g;
    @(posedge clk);
    #1;
    if (d) begin dbg_req = 1'b1; dbg_addr = a; end
    else begin core_req = 1'b1; core_addr = a; end
    do begin
      @(negedge clk);
      g = d ? dbg_gnt : core_gnt;
      n++;
    end while (!g && n < 20);
    if (!g) chk("gnt_timeout", 0, 1);
    @(posedge clk);
    #1;
    core_req = 1'b0;
    dbg_req  = 1'b0;
    wait_drain();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        dbg;
    logic [13:0] addr;
  } vec_t;

  vec_t vecs[8];
  int   g[3];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 14'h0000};
    vecs[1] = '{1'b0, 14'h0004};
    vecs[2] = '{1'b1, 14'h0008};
    vecs[3] = '{1'b1, 14'h0006};  // misaligned
    vecs[4] = '{1'b1, 14'h0504};  // index 321
    vecs[5] = '{1'b0, 14'h0500};  // index 320, last valid
    vecs[6] = '{1'b0, 14'h0002};
    vecs[7] = '{1'b1, 14'h3FFC};

    // Reset state, with a request pending that must not be granted.
    core_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_core_gnt", core_gnt, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_flags", {core_rvalid, core_err, dbg_rvalid, dbg_err, dbg_gnt}, 0);
    @(posedge clk);
    #1;
    core_req = 1'b0;
    rst = 1'b0;

    // Basic core fetch with explicit per-cycle checks.
    @(posedge clk);
    #1;
    core_req = 1'b1;
    core_addr = 14'h0018;
    @(negedge clk);
    chk("basic_gnt_T", core_gnt, 1);
    @(posedge clk);
    #1;
    core_req = 1'b0;
    @(negedge clk);
    chk("basic_rom_addr_T1", rom_addr, 14'h0018);
    @(negedge clk);
    chk("basic_no_rvalid_T2", core_rvalid, 0);
    @(negedge clk);
    chk("basic_rvalid_T3", core_rvalid, 1);
    chk("basic_rdata_T3", core_rdata, rom_word(12'd6));
    wait_drain();

    for (int i = 0; i < 8; i++) access(vecs[i].dbg, vecs[i].addr);

    // Back-to-back core fetch: req held, address advanced after each grant.
    @(posedge clk);
    #1;
    core_req = 1'b1;
    core_addr = 14'h0000;
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!core_gnt && n < 10);
      if (!core_gnt) chk("b2b_gnt_timeout", 0, 1);
      g[i] = cyc;
      @(posedge clk);
      #1;
      if (i < 2) core_addr = 14'(4 * (i + 1));
      else core_req = 1'b0;
    end
    chk("b2b_gap0", g[1] - g[0], 3);
    chk("b2b_gap1", g[2] - g[1], 3);
    wait_drain();

    // Data hold: a debug access leaves the core response registers alone.
    access(1'b0, 14'h0030);
    access(1'b1, 14'h0034);
    chk("hold_core_rdata", core_rdata, mdl_core_rdata);
    chk("hold_core_rdata_abs", core_rdata, rom_word(12'd12));
    chk("hold_core_err", core_err, mdl_core_err);

    // Contention from a fresh reset.
    do_reset();
    gnt_log.delete();
    @(posedge clk);
    #1;
    core_req = 1'b1;
    core_addr = 14'h0010;
    dbg_req = 1'b1;
    dbg_addr = 14'h0020;
    begin
      int n = 0;
      while (gnt_log.size() < 4 && n < 40) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    @(posedge clk);
    #1;
    core_req = 1'b0;
    dbg_req = 1'b0;
    chk("cont_count", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
`ifdef IMEM_ARB_RR_EN
      if (i < gnt_log.size()) chk("cont_order_rr", gnt_log[i], i % 2);
`else
      if (i < gnt_log.size()) chk("cont_order_fixed", gnt_log[i], 0);
`endif
    end
    wait_drain();

    // Reset one cycle after a grant drops the access.
    @(posedge clk);
    #1;
    core_req = 1'b1;
    core_addr = 14'h0040;
    @(negedge clk);
    chk("rstmid_gnt_T", core_gnt, 1);
    @(posedge clk);
    #1;
    core_req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_rom_addr", rom_addr, 0);
    chk("rstmid_rdata", {core_rdata, dbg_rdata}, 0);
    chk("rstmid_flags_T2", {core_rvalid, core_err, dbg_rvalid, dbg_err}, 0);
    @(negedge clk);
    chk("rstmid_rvalid_T3", {core_rvalid, dbg_rvalid}, 0);
    access(1'b0, 14'h0044);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter and sequencer for the single-port instruction ROM of the multicycle RISC-V core. Shares the ROM's registered, one-cycle-latency read port between the core fetch unit and a debug/loader read port. Handles address checking, grant, ROM address issue, data capture and per-requester response signalling. Sits between the fetch stage, the debug module and the instruction ROM.

## Interface

**Parameters**
- `ADDR_W`, 14: byte address width; matches the ROM `i_addr` width.
- `DATA_W`, 32: instruction word width.
- `INSTR_CNT`, 321: number of valid ROM words; word index `addr[ADDR_W-1:2] >= INSTR_CNT` is out of range.

**Ports**
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `core_req`  in  1  core fetch request; level-sensitive.
- `core_addr`  in  ADDR_W  core byte address.
- `core_gnt`  out  1  one-cycle pulse: core request accepted this cycle.
- `core_rvalid`  out  1  one-cycle pulse: core response valid.
- `core_rdata`  out  DATA_W  core response data; held until the next core response.
- `core_err`  out  1  qualifies `core_rvalid`: misaligned or out-of-range access.
- `dbg_req`, `dbg_addr`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`, `dbg_err`: same as the core set, for the debug port.
- `rom_addr`  out  ADDR_W  registered address to ROM `i_addr`.
- `rom_data`  in  DATA_W  ROM `o_data`, valid one cycle after `rom_addr` is presented.

## Operation

- **FSM states:** `IDLE`, `ISSUE`, `CAPTURE`. Only one access is outstanding at a time.
- **IDLE:**
  - If any `req` is high, grant one requester and pulse its `gnt` combinationally in that cycle.
  - On the same edge: register the granted address into `rom_addr`, latch the requester ID and the error flag, then go to `ISSUE`.
  - With no request, stay in `IDLE`.
- **ISSUE:** `rom_addr` is stable; the ROM samples it at the end of this cycle. Go to `CAPTURE`.
- **CAPTURE:**
  - `rom_data` is valid.
  - At the end of the cycle, load the owner's `rdata` register:
    - with `rom_data` when the error flag is clear;
    - with 0 when the error flag is set.
  - Load the owner's `err` register from the error flag.
  - Set the owner's `rvalid` for the next cycle, then go to `IDLE`.
- **Error flag:** `addr[1:0] != 0` or word index `>= INSTR_CNT`. An erroring access still takes the full 3-cycle sequence; `rom_addr` is driven normally.
- **Requester rules:**
  - Hold `req` high with a stable `addr` until `gnt`.
  - The address is sampled only in the `gnt` cycle.
  - Keeping `req` high after `gnt` requests a further access.
  - Dropping `req` before `gnt` withdraws the request with no side effect.
- **Output holding:** `rdata`/`err` of each port hold their values until that port's next response. `rom_addr` holds its last value between accesses.
- **Arbitration:** when only one port requests, that port wins. Simultaneous requests are resolved per Configuration.
- **Reset:**
  - `rst` high at an edge forces `IDLE` and drops any in-flight access; no `rvalid` is ever issued for it.
  - Reset values: all `gnt`, `rvalid`, `err` = 0; all `rdata` = 0; `rom_addr` = 0; round-robin pointer = "debug last".
  - No `gnt` is issued in a cycle where `rst` is high.

## Timing

- Request in `IDLE` at cycle T: `gnt` is high in T; `rom_addr` is valid in T+1; `rom_data` is valid in T+2.
- `rvalid`/`rdata`/`err` are valid in T+3.
- The T+3 cycle is `IDLE`, so a new grant may occur in the same cycle as the previous `rvalid`.
- Maximum throughput: one access per 3 cycles. Latency from grant to `rvalid` is exactly 3 cycles.
- `gnt` is combinational from `req` and state. `rvalid`, `rdata`, `err` and `rom_addr` are registered.

## Configuration

- **`IMEM_ARB_RR_EN` defined:** round-robin.
  - On simultaneous requests, the port not granted last wins.
  - The pointer updates on every grant.
  - After reset the core wins the first tie.
  - Continuous requests from both ports alternate grants core, dbg, core, …
- **`IMEM_ARB_RR_EN` undefined:** fixed priority; the core always wins ties.
  - Debug may starve while `core_req` is held high.
  - No pointer register is built.

## Test plan

- **Basic core fetch:** `core_req` with `core_addr`=0x0018 at cycle T → `core_gnt` in T, `rom_addr`=0x0018 in T+1, `core_rvalid`=1 in T+3 with `core_rdata`=ROM word 6, `core_err`=0.
- **Back-to-back core fetch:** `core_req` held with addresses 0x0, 0x4, 0x8 → grants at T, T+3, T+6; three `rvalid` pulses at T+3, T+6, T+9 with the matching words.
- **Errors:**
  - `dbg_addr`=0x0006 → `dbg_rvalid` at T+3, `dbg_err`=1, `dbg_rdata`=0.
  - `dbg_addr`=0x0504 (index 321) → `dbg_err`=1, `dbg_rdata`=0.
- **Contention:** both `req` held for 4 accesses.
  - With `IMEM_ARB_RR_EN`: grant order core, dbg, core, dbg.
  - Without it: 4 core grants and no `dbg_gnt`.
- **Reset mid-access:** grant at T, `rst` high at T+1 → no `rvalid` on either port; all outputs 0 from T+2. A request at T+3 is serviced normally.
- **Data hold:** after a core response, a following debug access must leave `core_rdata`/`core_err` unchanged.
